// File: rtl/valet_event_sequencer.sv
// Event source for the valet arena: LFSR-driven ARRIVE/RETURN picks against a parked-car bitmap,
// handed off on valid/ready. Define VALET_CHAOS_EN to also emit CHAOS interference events.
module valet_event_sequencer #(
    parameter int          MAX_CARS   = 16,
    parameter int          ARRIVE_GAP = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        evt_ready,
    output logic        evt_valid,
    output logic [7:0]  evt_data,
    output logic [6:0]  occupied_count,
    output logic [15:0] event_count
);
    localparam int              IW         = (MAX_CARS > 1) ? $clog2(MAX_CARS) : 1;
    localparam int              GW         = (ARRIVE_GAP > 1) ? $clog2(ARRIVE_GAP) : 1;
    localparam logic [GW-1:0]   GAP_LOAD   = GW'(ARRIVE_GAP - 1);
    localparam logic [6:0]      FULL_COUNT = 7'(MAX_CARS);
    localparam logic [15:0]     SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]     LFSR_MASK  = 16'hB400;
    localparam logic [1:0]      OP_ARRIVE  = 2'b01;
    localparam logic [1:0]      OP_RETURN  = 2'b10;
`ifdef VALET_CHAOS_EN
    localparam logic [1:0]      OP_CHAOS   = 2'b11;
`endif

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_PICK, S_SEND} state_t;

    state_t              state_reg;
    logic [GW-1:0]       gap_reg;
    logic [15:0]         lfsr_reg;
    logic [15:0]         lfsr_next;
    logic [MAX_CARS-1:0] parked_reg;
    logic                evt_valid_reg;
    logic [7:0]          evt_data_reg;
    logic [6:0]          occupied_reg;
    logic [15:0]         event_count_reg;

    logic [IW-1:0]       return_start;
    logic [IW-1:0]       return_off;
    logic [IW-1:0]       return_id;
    logic [IW-1:0]       arrive_id;
    logic [IW-1:0]       send_id;
    logic [MAX_CARS-1:0] rotated;
    logic [7:0]          pick_data;

    assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_MASK) : (lfsr_reg >> 1);

    // Rotate the bitmap so the wrapping RETURN scan becomes a plain lowest-set-bit search.
    assign return_start = lfsr_reg[IW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_CARS; gi++) begin : g_rotate
            assign rotated[gi] = parked_reg[return_start + IW'(gi)];
        end
    endgenerate

    always_comb begin
        arrive_id  = '0;
        return_off = '0;
        for (int i = MAX_CARS - 1; i >= 0; i--) begin
            if (!parked_reg[i]) arrive_id = IW'(i);
            if (rotated[i]) return_off = IW'(i);
        end
    end

    assign return_id = return_start + return_off;

    always_comb begin
        pick_data = {OP_ARRIVE, 6'(arrive_id)};
        if ((occupied_reg != 7'd0) && ((occupied_reg == FULL_COUNT) || lfsr_reg[0]))
            pick_data = {OP_RETURN, 6'(return_id)};
`ifdef VALET_CHAOS_EN
        if (lfsr_reg[15:12] == 4'hF)
            pick_data = {OP_CHAOS, lfsr_reg[5:0]};
`endif
    end

    assign send_id = evt_data_reg[IW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            gap_reg         <= '0;
            lfsr_reg        <= SEED;
            parked_reg      <= '0;
            evt_valid_reg   <= 1'b0;
            evt_data_reg    <= 8'h00;
            occupied_reg    <= 7'd0;
            event_count_reg <= 16'd0;
        end else begin
            lfsr_reg <= lfsr_next;
            case (state_reg)
                S_IDLE: begin
                    if (enable) begin
                        gap_reg   <= GAP_LOAD;
                        state_reg <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!enable)
                        state_reg <= S_IDLE;
                    else if (gap_reg == '0)
                        state_reg <= S_PICK;
                    else
                        gap_reg <= gap_reg - GW'(1);
                end
                S_PICK: begin
                    evt_data_reg  <= pick_data;
                    evt_valid_reg <= 1'b1;
                    state_reg     <= S_SEND;
                end
                S_SEND: begin
                    // Held until accepted; enable only decides where we go afterwards.
                    if (evt_ready) begin
                        evt_valid_reg <= 1'b0;
                        case (evt_data_reg[7:6])
                            OP_ARRIVE: begin
                                parked_reg[send_id] <= 1'b1;
                                occupied_reg        <= occupied_reg + 7'd1;
                            end
                            OP_RETURN: begin
                                parked_reg[send_id] <= 1'b0;
                                occupied_reg        <= occupied_reg - 7'd1;
                            end
                            default: ;
                        endcase
                        if (event_count_reg != 16'hFFFF)
                            event_count_reg <= event_count_reg + 16'd1;
                        if (enable) begin
                            gap_reg   <= GAP_LOAD;
                            state_reg <= S_GAP;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign evt_valid      = evt_valid_reg;
    assign evt_data       = evt_data_reg;
    assign occupied_count = occupied_reg;
    assign event_count    = event_count_reg;

endmodule
